// File: rtl/dbg_pkg.sv
// dbg_pkg: shared definitions for the debug serial bridge.
//   BUSWIDTH_DEF / REGNUMLOG2_DEF : default register data / address widths
//   OP_WRITE / OP_READ            : frame op bit values
//   dbg_state_e                   : bridge FSM state encoding
package dbg_pkg;

  localparam int unsigned BUSWIDTH_DEF   = 32;
  localparam int unsigned REGNUMLOG2_DEF = 5;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RDFETCH,
    DATA,
    COMMIT,
    WAIT_CS
  } dbg_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer for an asynchronous level plus
// single-cycle rise/fall pulses taken from the synchronized value.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
// Parameter RST_VAL is the idle level all flops take in reset, so no
// spurious edge is seen when reset is released with the input idle.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/dbg_serial_bridge.sv
// dbg_serial_bridge: serial debug port into the register file write/read
// ports. A frame (cs_n low) carries op, address, then data, MSB first,
// sampled on sck rising edges.
//   clk, rst            : system clock, synchronous active-high reset
//   dbg_sck/cs_n/sdi    : host serial interface (asynchronous to clk)
//   dbg_sdo             : readback data, advances on sck falling edges
//   core_wen            : core writeback this cycle (wins the port)
//   jtag_wen/waddr/wdata: debug write request
//   jtag_raddr/rdata    : debug read port (rdata combinational)
//   busy                : any state other than IDLE
//   frame_err           : one-cycle pulse on abort / rejected frame
// Macro DBG_SERIAL_READBACK_EN enables reads; without it read frames are
// rejected and dbg_sdo / jtag_raddr are tied to 0.
module dbg_serial_bridge
  import dbg_pkg::*;
#(
  parameter int unsigned BUSWIDTH   = BUSWIDTH_DEF,
  parameter int unsigned REGNUMLOG2 = REGNUMLOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dbg_sck,
  input  logic                  dbg_cs_n,
  input  logic                  dbg_sdi,
  output logic                  dbg_sdo,
  input  logic                  core_wen,
  output logic                  jtag_wen,
  output logic [REGNUMLOG2-1:0] jtag_waddr,
  output logic [BUSWIDTH-1:0]   jtag_wdata,
  output logic [REGNUMLOG2-1:0] jtag_raddr,
  input  logic [BUSWIDTH-1:0]   jtag_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned CW = $clog2(BUSWIDTH + REGNUMLOG2 + 1);

  dbg_state_e state_q, state_d;

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic sdi_meta_q, sdi_q;
  logic op_q;
  logic [REGNUMLOG2-1:0] addr_q;
  logic [BUSWIDTH-1:0]   data_q;
  logic [CW-1:0]         bit_cnt_q;
  logic cs_seen_q;
  logic last_addr, last_data, accept, err_d;

  sync_edge_detect #(.RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(dbg_sck), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_detect #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(dbg_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // sdi gets the same two-flop delay as sck so the sample taken on the
  // detected rise lines up with the host's data at that sck edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdi_meta_q <= 1'b0;
      sdi_q      <= 1'b0;
    end else begin
      sdi_meta_q <= dbg_sdi;
      sdi_q      <= sdi_meta_q;
    end
  end

  // Bit 0 of the frame is op, bits 1..REGNUMLOG2 are the address.
  assign last_addr = sck_rise && (bit_cnt_q == CW'(REGNUMLOG2));
  assign last_data = sck_rise && (bit_cnt_q == CW'(BUSWIDTH - 1));
  assign jtag_wen  = (state_q == COMMIT) && !rst;
  assign accept    = jtag_wen && !core_wen;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (cs_fall) state_d = CMD;
      CMD: begin
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (last_addr) begin
          if (op_q == OP_WRITE) begin
            state_d = DATA;
          end else begin
`ifdef DBG_SERIAL_READBACK_EN
            state_d = RDFETCH;
`else
            state_d = WAIT_CS;
            err_d   = 1'b1;
`endif
          end
        end
      end
`ifdef DBG_SERIAL_READBACK_EN
      RDFETCH: begin
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = DATA;
        end
      end
`endif
      DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (last_data) begin
          if (op_q == OP_WRITE && addr_q != '0) state_d = COMMIT;
          else                                  state_d = WAIT_CS;
        end
      end
      // cs_n may rise while the commit is stalled; remember it so the
      // frame ends in IDLE instead of waiting for a rise already gone.
      COMMIT: if (accept) state_d = (cs_seen_q || cs_rise) ? IDLE : WAIT_CS;
      WAIT_CS: if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      cs_seen_q <= 1'b0;
    end else begin
      cs_seen_q <= (state_q == COMMIT) && (cs_seen_q || cs_rise);
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            op_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            bit_cnt_q <= last_addr ? '0 : bit_cnt_q + CW'(1);
            if (bit_cnt_q == '0) op_q <= sdi_q;
            else addr_q <= (addr_q << 1) | REGNUMLOG2'(sdi_q);
          end
        end
        DATA: begin
          if (sck_rise) begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
            if (op_q == OP_WRITE) data_q <= (data_q << 1) | BUSWIDTH'(sdi_q);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DBG_SERIAL_READBACK_EN
  logic [BUSWIDTH-1:0] out_sr_q;

  always_ff @(posedge clk) begin
    if (rst)                                 out_sr_q <= '0;
    else if (state_q == RDFETCH)             out_sr_q <= jtag_rdata;
    else if (state_q == DATA && sck_fall)    out_sr_q <= out_sr_q << 1;
  end

  assign dbg_sdo    = out_sr_q[BUSWIDTH-1];
  assign jtag_raddr = addr_q;
`else
  logic unused_rd;
  assign unused_rd  = ^{jtag_rdata, sck_fall};
  assign dbg_sdo    = 1'b0;
  assign jtag_raddr = '0;
`endif

  assign jtag_waddr = addr_q;
  assign jtag_wdata = data_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = err_d && !rst;

endmodule

// File: doc/dbg_serial_bridge.md
DBG_SERIAL_BRIDGE -- requirements
Module: dbg_serial_bridge

Interface
- REQ-001: The block SHALL have parameter BUSWIDTH, default 32, which sets the register data width.
- REQ-002: The block SHALL have parameter REGNUMLOG2, default 5, which sets the register address width.
- REQ-003: clk  in  1  system clock; all logic SHALL be on its rising edge.
- REQ-004: rst  in  1  reset, synchronous, active-high.
- REQ-005: dbg_sck  in  1  serial clock from the host, asynchronous to clk.
- REQ-006: dbg_cs_n  in  1  frame select, active-low, asynchronous to clk.
- REQ-007: dbg_sdi  in  1  serial data in, MSB first.
- REQ-008: dbg_sdo  out  1  serial readback data, MSB first.
- REQ-009: core_wen  in  1  core writeback active this cycle; a core write wins the register-file port.
- REQ-010: jtag_wen  out  1  debug write request to the register file.
- REQ-011: jtag_waddr  out  REGNUMLOG2  debug write address.
- REQ-012: jtag_wdata  out  BUSWIDTH  debug write data.
- REQ-013: jtag_raddr  out  REGNUMLOG2  debug read address.
- REQ-014: jtag_rdata  in  BUSWIDTH  register-file read data, combinational from jtag_raddr.
- REQ-015: busy  out  1  a frame or a commit is in progress.
- REQ-016: frame_err  out  1  one-cycle pulse when a frame is aborted or rejected.

Function
- REQ-017: dbg_sck and dbg_cs_n SHALL pass through a 2-FF synchronizer; edges SHALL be detected on the synchronized values; dbg_sdi SHALL be sampled together with the synchronized sck rising edge; clk SHALL be at least 4x the sck frequency.
- REQ-018: A frame SHALL start on a cs_n falling edge and contain 1+REGNUMLOG2+BUSWIDTH bits: op (1=write, 0=read), then address, then data.
- REQ-019: The FSM SHALL have the states IDLE, CMD, RDFETCH, DATA, COMMIT and WAIT_CS.
  - IDLE->CMD on a cs_n fall.
  - CMD->DATA after the last address bit on a write.
  - CMD->RDFETCH after the last address bit on a read.
  - RDFETCH->DATA after 1 cycle.
  - DATA->COMMIT after the last data bit on a write.
  - DATA->WAIT_CS after the last data bit on a read.
  - COMMIT->WAIT_CS on accept.
  - WAIT_CS->IDLE on a cs_n rise.
- REQ-020: In RDFETCH, jtag_raddr SHALL equal the shifted address, and jtag_rdata SHALL be loaded into the output shift register at the end of that cycle.
- REQ-021: On a read, dbg_sdo SHALL present data[BUSWIDTH-1] on entry to DATA and SHALL advance one bit on each synchronized sck falling edge; data bits received from the host during a read SHALL be ignored.
- REQ-022: In COMMIT, jtag_wen SHALL be held high with jtag_waddr and jtag_wdata stable; accept = jtag_wen && !core_wen; the commit SHALL hold while core_wen is high.
- REQ-023: A write to address 0 SHALL complete the frame without asserting jtag_wen.
- REQ-024: A cs_n rise in CMD, RDFETCH or DATA SHALL abort the frame: no write, frame_err pulsed 1 cycle, next state IDLE.
- REQ-025: A cs_n rise in COMMIT SHALL NOT abort the frame; the write SHALL complete, then the FSM SHALL go to IDLE.
- REQ-026: sck edges in WAIT_CS and IDLE SHALL be ignored.
- REQ-027: busy SHALL be high in every state other than IDLE.

Reset
- REQ-028: While rst is high, the block SHALL be in IDLE.
- REQ-029: While rst is high, jtag_wen, jtag_waddr, jtag_wdata, jtag_raddr, dbg_sdo, busy, frame_err and the shift registers SHALL all be 0.
- REQ-030: The synchronizer flops SHALL reset to sck=0, cs_n=1.
- REQ-031: A reset during COMMIT SHALL drop the pending write.

Configuration
- REQ-032: The macro DBG_SERIAL_READBACK_EN SHALL control readback.
- REQ-033: With DBG_SERIAL_READBACK_EN defined, reads SHALL follow REQ-020 and REQ-021.
- REQ-034: Without DBG_SERIAL_READBACK_EN, RDFETCH and the output shift register SHALL be removed and dbg_sdo and jtag_raddr SHALL be tied to 0.
- REQ-035: Without DBG_SERIAL_READBACK_EN, a read frame SHALL pulse frame_err after the address bits and go to WAIT_CS.

Structure
- REQ-036: Package dbg_pkg SHALL hold the default BUSWIDTH and REGNUMLOG2, the state enum typedef, and the op constants OP_WRITE and OP_READ.
- REQ-037: Sub-module sync_edge_detect (2-FF sync plus rise/fall pulses, reset value as a parameter) SHALL be instantiated for dbg_sck and dbg_cs_n.

Verification
- REQ-038: Write frame op=1, addr=5, data=0xDEADBEEF, core_wen=0 -> exactly one jtag_wen cycle with waddr=5 and wdata=0xDEADBEEF; busy low after cs_n rise.
- REQ-039: Same write with core_wen held high for 3 cycles across COMMIT -> jtag_wen high for 4 cycles, data stable, a single accept.
- REQ-040: Read frame op=0, addr=7 with jtag_rdata model returning 0x12345678 -> dbg_sdo bits 0x12345678 MSB first; jtag_raddr=7 in RDFETCH.
- REQ-041: cs_n raised after 20 bits of a write -> frame_err one pulse, no jtag_wen, and a following valid frame works.
- REQ-042: Write to addr 0, data 0xFFFFFFFF -> no jtag_wen and no frame_err.
- REQ-043: Build without DBG_SERIAL_READBACK_EN and send a read addr=3 -> frame_err pulse, dbg_sdo constant 0; build with the macro and issue rst mid-COMMIT -> no write and all outputs 0.
